serial_adder_sub: RTL

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock through one registered carry chain. Operands enter and results leave over valid/ready handshakes. It is the area-lean replacement for wide ripple adders on non-critical datapaths in the arithmetic library, and adds subtract mode plus signed-overflow detection.

---
 rtl/serial_adder_sub.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_adder_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// valid/ready on both sides, carry-out/no-borrow and signed overflow flags.
module serial_adder_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_adder_sub: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [31:0]      w_sh;
    logic [WIDTH-1:0] w_ash;
    logic [WIDTH-1:0] w_bsh;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT-1:0] w_ds;
    logic [DIGIT:0]   w_dadd;
    logic             w_dc;
    logic             w_cmsb;
    logic             w_last;

    // Current digit is picked by shifting, so no variable part-selects.
    assign w_sh   = 32'(r_cnt) * 32'(DIGIT);
    assign w_ash  = r_a >> w_sh;
    assign w_bsh  = r_b >> w_sh;
    assign w_da   = w_ash[DIGIT-1:0];
    assign w_db   = w_bsh[DIGIT-1:0];
    assign w_dadd = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};
    assign w_ds   = w_dadd[DIGIT-1:0];
    assign w_dc   = w_dadd[DIGIT];
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
    assign w_cmsb = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_ds[DIGIT-1];
    assign w_last = (r_cnt == CW'(N - 1));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)  w_state_nx = S_RUN;
            S_RUN:  if (w_last)    w_state_nx = S_DONE;
            S_DONE: if (out_ready) w_state_nx = S_IDLE;
            default:               w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= c_in ^ sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= (r_sum & ~(DMASK << w_sh))
                             | (WIDTH'(w_ds) << w_sh);
                    r_carry <= w_dc;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_cout <= w_dc;
                        r_ovf  <= w_cmsb ^ w_dc;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
